reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares one DATA_W-bit load-enabled Register (clk, rst, load, data_in) among NUM_REQ requesters. It selects one pending requester and captures its data. It then drives a single-cycle load pulse into the Register and returns a one-cycle ack to the winner. It sits between the requesting datapath units and the shared Register.

---
 rtl/reg_write_arbiter.sv | 115 +++++++++++
 tb/tb_reg_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sharing one load-enabled register among requesters
// Define REG_ARB_READBACK_EN to add a CHECK state comparing reg_q against the written data.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       reg_load,
  output logic [DATA_W-1:0]          reg_data_in,
  input  logic [DATA_W-1:0]          reg_q,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_ACK} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [IDX_W-1:0]    win_idx, cand_idx, owner_n;
  logic                win_found;
  int                  cand;
  logic                load_n, busy_n;
  logic [NUM_REQ-1:0]  ack_n;
  logic [DATA_W-1:0]   data_n;

  // First pending request at or above ptr, wrapping past the top index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (win_found) state_n = S_LOAD;
`ifdef REG_ARB_READBACK_EN
      S_LOAD:  state_n = S_CHECK;
`else
      S_LOAD:  state_n = S_ACK;
`endif
      S_CHECK: state_n = S_ACK;
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values for the registered outputs, derived from the upcoming state.
  always_comb begin
    owner_n = owner;
    data_n  = reg_data_in;
    ptr_n   = ptr;
    if (state == S_IDLE && win_found) begin
      owner_n = win_idx;
      data_n  = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end
    if (state == S_ACK) ptr_n = (owner == LAST_IDX) ? '0 : owner + 1'b1;
    load_n = (state_n == S_LOAD);
    busy_n = (state_n != S_IDLE);
    ack_n  = (state_n == S_ACK) ? (NUM_REQ'(1) << owner_n) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      owner       <= '0;
      reg_data_in <= '0;
      reg_load    <= 1'b0;
      busy        <= 1'b0;
      ack         <= '0;
    end else begin
      ptr         <= ptr_n;
      owner       <= owner_n;
      reg_data_in <= data_n;
      reg_load    <= load_n;
      busy        <= busy_n;
      ack         <= ack_n;
    end
  end

`ifdef REG_ARB_READBACK_EN
  // Register has captured reg_data_in by CHECK; any difference is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        err <= 1'b0;
    else if (state == S_CHECK && reg_q != reg_data_in) err <= 1'b1;
  end
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - bench for reg_write_arbiter
// Vector table, hand sequences and a transaction-level random model; honours REG_ARB_READBACK_EN.
module tb_reg_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef REG_ARB_READBACK_EN
  localparam int ACKOFF = 2;
`else
  localparam int ACKOFF = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  ack;
  logic          reg_load;
  logic [W-1:0]  reg_data_in;
  logic [W-1:0]  reg_q;
  logic          busy;
  logic [1:0]    owner;
  logic          err;
  logic [W-1:0]  reg_mem = 8'h00;
  logic          force_bad = 1'b0;

  int total = 0;
  int bad   = 0;

  reg_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .reg_load(reg_load), .reg_data_in(reg_data_in), .reg_q(reg_q),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  // The shared Register; it has no reset of its own here.
  always @(posedge clk) if (reg_load) reg_mem <= reg_data_in;
  assign reg_q = force_bad ? 8'h00 : reg_mem;

  typedef struct {
    bit         do_rst;
    logic [3:0] rq;
    logic [31:0] d;
    logic       ld;
    logic [3:0] ak;
    logic       bz;
    logic [1:0] ow;
    logic [7:0] di;
    bit         chk_reg;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    force_bad = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  function automatic void add(input bit r, input logic [3:0] rq, input logic [31:0] d,
                              input logic ld, input logic [3:0] ak, input logic bz,
                              input logic [1:0] ow, input logic [7:0] di, input bit cr);
    vec_t v;
    v.do_rst = r; v.rq = rq; v.d = d; v.ld = ld; v.ak = ak;
    v.bz = bz; v.ow = ow; v.di = di; v.chk_reg = cr;
    vecs.push_back(v);
  endfunction

  function automatic void add_txn(input logic [3:0] rq, input logic [3:0] rq_after,
                                  input logic [31:0] d, input int w);
    logic [7:0] di;
    logic [3:0] oh;
    di = d[w*8 +: 8];
    oh = 4'b0001 << w;
    add(0, rq, d, 1'b1, 4'b0000, 1'b1, 2'(w), di, 0);
    if (ACKOFF == 2) add(0, rq, d, 1'b0, 4'b0000, 1'b1, 2'(w), di, 0);
    add(0, rq, d, 1'b0, oh, 1'b1, 2'(w), di, 0);
    add(0, rq_after, d, 1'b0, 4'b0000, 1'b0, 2'(w), di, 1);
  endfunction

  // Transaction-level reference: grant edge, owner, data and rotation pointer.
  int          m_g;
  int          m_e;
  int          m_ptr;
  int          m_owner;
  logic [7:0]  m_din;
  bit          m_any;

  initial begin
    // Reset state
    rst = 1'b0;
    step();
    chk("rst reg_load", reg_load, 0);
    chk("rst ack", ack, 0);
    chk("rst busy", busy, 0);
    chk("rst owner", owner, 0);
    chk("rst reg_data_in", reg_data_in, 0);
    chk("rst err", err, 0);

    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_txn(4'b0001, 4'b0000, 32'h000000AA, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add_txn(4'b1111, 4'b1111, 32'h13121110, k % 4);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_txn(4'b0100, 4'b0101, 32'h00320030, 2);
    add_txn(4'b0101, 4'b0100, 32'h00320030, 0);
    add_txn(4'b0100, 4'b0000, 32'h00320030, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) begin
        do_reset();
      end else begin
        req      = vecs[i].rq;
        req_data = vecs[i].d;
        step();
        chk($sformatf("v%0d reg_load", i), reg_load, vecs[i].ld);
        chk($sformatf("v%0d ack", i), ack, vecs[i].ak);
        chk($sformatf("v%0d busy", i), busy, vecs[i].bz);
        chk($sformatf("v%0d owner", i), owner, vecs[i].ow);
        chk($sformatf("v%0d reg_data_in", i), reg_data_in, vecs[i].di);
        if (vecs[i].chk_reg) chk($sformatf("v%0d register", i), reg_mem, vecs[i].di);
      end
    end

    // Owner data changed during LOAD does not reach the Register
    do_reset();
    req = 4'b0010;
    req_data = 32'h00004400;
    step();
    chk("hold load", reg_load, 1);
    req_data = 32'h0000FF00;
    for (int k = 0; k < ACKOFF; k++) step();
    chk("hold ack", ack, 4'b0010);
    chk("hold register", reg_mem, 8'h44);
    req = 4'b0000;
    step();
    step();
    chk("hold reg_data_in", reg_data_in, 8'h44);
    chk("hold register idle", reg_mem, 8'h44);

    // Reset during LOAD aborts and restarts the rotation at 0
    do_reset();
    req = 4'b0100;
    req_data = 32'h00550000;
    step();
    for (int k = 0; k < ACKOFF; k++) step();
    req = 4'b1000;
    step();
    req_data = 32'h66000000;
    step();
    chk("abort owner", owner, 3);
    chk("abort load before", reg_load, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort async load", reg_load, 0);
    chk("abort async busy", busy, 0);
    chk("abort async ack", ack, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("abort no ack", ack, 0);
    end
    rst = 1'b1;
    req = 4'b1010;
    req_data = 32'h77008800;
    step();
    chk("post-abort owner", owner, 1);
    chk("post-abort load", reg_load, 1);
    chk("post-abort data", reg_data_in, 8'h88);
    for (int k = 0; k < ACKOFF; k++) step();
    chk("post-abort ack", ack, 4'b0010);
    req = 4'b0000;
    step();

`ifdef REG_ARB_READBACK_EN
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000005A;
    force_bad = 1'b1;
    step();
    chk("rb load", reg_load, 1);
    step();
    chk("rb err in check", err, 0);
    chk("rb no early ack", ack, 0);
    step();
    chk("rb ack cycle3", ack, 4'b0001);
    chk("rb err set", err, 1);
    req = 4'b0000;
    force_bad = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("rb err sticky", err, 1);
    rst = 1'b0;
    #1;
    chk("rb err cleared", err, 0);
`endif

    // Randomized traffic against the transaction model
    do_reset();
    m_g = -100; m_e = 0; m_ptr = 0; m_owner = 0; m_din = 8'h00; m_any = 0;
    for (int c = 0; c < 3000; c++) begin
      int d;
      logic [3:0] exp_ack;
      req      = (c < 1500) ? 4'($urandom_range(0, 15)) : (4'($urandom_range(0, 15)) | 4'b1001);
      req_data = $urandom;
      if (m_e - m_g >= ACKOFF + 2 && req != 0) begin
        for (int k = 0; k < N; k++) begin
          int w;
          w = (m_ptr + k) % N;
          if (m_e != m_g && req[w]) begin
            m_g     = m_e;
            m_owner = w;
            m_din   = req_data[w*8 +: 8];
            m_ptr   = (w + 1) % N;
            m_any   = 1;
          end
        end
      end
      step();
      d = m_e - m_g;
      exp_ack = (d == ACKOFF) ? (4'b0001 << m_owner) : 4'b0000;
      chk("rnd reg_load", reg_load, (d == 0));
      chk("rnd ack", ack, exp_ack);
      chk("rnd busy", busy, (d >= 0 && d <= ACKOFF));
      chk("rnd owner", owner, m_owner);
      chk("rnd reg_data_in", reg_data_in, m_din);
      if (m_any && d >= 1) chk("rnd register", reg_mem, m_din);
      chk("rnd err", err, 0);
      m_e++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
